// File: rtl/ualink_pkg.sv
`default_nettype none
// ualink_pkg: opcodes, header templates, beat counts and FSM encoding shared by the response path.
// Rev 1.0
package ualink_pkg;

  localparam logic [7:0] OP_REQ_RD   = 8'h01;
  localparam logic [7:0] OP_REQ_WR   = 8'h02;
  localparam logic [7:0] OP_RSP_RD   = 8'h81;
  localparam logic [7:0] OP_RSP_WACK = 8'h82;

  localparam logic [3:0] BEATS_WACK = 4'd6;
  localparam logic [3:0] BEATS_RRSP = 4'd14;
  localparam logic [3:0] FETCH_WORDS = 4'd8;

  localparam int BUF_DEPTH = 8;
  localparam int BUF_IDX_W = 3;

  localparam logic [63:0] HDR_RRSP_2 = 64'hC0A8_0001_0011_4000;
  localparam logic [63:0] HDR_RRSP_3 = 64'hB0B0_0000_C0A8_0002;
  localparam logic [63:0] HDR_RRSP_4 = 64'h0070_0000_1389_1389;
  localparam logic [63:0] HDR_WACK_2 = 64'h2A00_0001_0011_4000;
  localparam logic [63:0] HDR_WACK_3 = 64'hB0B0_0000_2A00_0002;
  localparam logic [63:0] HDR_WACK_4 = 64'h0030_0000_1389_1389;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HDR   = 2'd2,
    ST_DATA  = 2'd3
  } state_e;

  // Fixed header words 2..4; any other index yields zero.
  function automatic logic [63:0] hdr_template(input logic is_rd, input logic [3:0] idx);
    logic [63:0] w;
    w = '0;
    case (idx)
      4'd2:    w = is_rd ? HDR_RRSP_2 : HDR_WACK_2;
      4'd3:    w = is_rd ? HDR_RRSP_3 : HDR_WACK_3;
      4'd4:    w = is_rd ? HDR_RRSP_4 : HDR_WACK_4;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ualink_rsp_buf.sv
`default_nettype none
// ualink_rsp_buf: 8x64 register buffer holding the fetched read-response payload.
// Rev 1.0
module ualink_rsp_buf
  import ualink_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [BUF_IDX_W-1:0] wr_idx_i,
  input  logic [63:0]          wr_data_i,
  input  logic [BUF_IDX_W-1:0] rd_idx_i,
  output logic [63:0]          rd_data_o
);

  logic [63:0] mem_q [BUF_DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/ualink_rsp_tx.sv
`default_nettype none
// ualink_rsp_tx: turns write-ack / read-response commands into 6- or 14-beat AXI4-Stream packets.
// Rev 1.0
module ualink_rsp_tx
  import ualink_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int MEM_ADDR_WIDTH       = 8
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_type,
  input  logic [63:0]                       cmd_key,
  input  logic [47:0]                       cmd_dst_mac,
  input  logic [47:0]                       cmd_src_mac,
  output logic                              mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic [63:0]                       mem_rd_data,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       pkt_cnt
);

  state_e      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic        is_rd_q;
  logic [63:0] key_q;
  logic [47:0] dst_q, src_q;
  logic        cmd_acc;
  logic        buf_we;
  logic [63:0] buf_rd;
  logic [63:0] hdr_word;

  // Fetch counter 1..8 writes slots 0..7; beats 6..13 read slots 0..7.
  ualink_rsp_buf u_buf (
    .clk_i     (axi_aclk),
    .wr_en_i   (buf_we),
    .wr_idx_i  (fcnt_q[2:0] - 3'd1),
    .wr_data_i (mem_rd_data),
    .rd_idx_i  (beat_q[2:0] + 3'd2),
    .rd_data_o (buf_rd)
  );

  always_comb begin
    hdr_word = key_q;
    case (beat_q)
      4'd0:             hdr_word = {src_q[15:0], dst_q};
      4'd1:             hdr_word = {(is_rd_q ? OP_RSP_RD : OP_RSP_WACK), 8'h45, 16'h0008, src_q[47:16]};
      4'd2, 4'd3, 4'd4: hdr_word = hdr_template(is_rd_q, beat_q);
      default:          hdr_word = key_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    fcnt_d        = fcnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    cmd_ready     = 1'b0;
    cmd_acc       = 1'b0;
    mem_rd_en     = 1'b0;
    mem_rd_addr   = '0;
    buf_we        = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = axi_resetn;
        if (cmd_valid && axi_resetn) begin
          cmd_acc = 1'b1;
          beat_d  = '0;
          fcnt_d  = '0;
          state_d = cmd_type ? ST_FETCH : ST_HDR;
        end
      end
      ST_FETCH: begin
        if (fcnt_q < FETCH_WORDS) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = key_q[MEM_ADDR_WIDTH-1:0] + MEM_ADDR_WIDTH'(fcnt_q);
        end
        buf_we = (fcnt_q != 4'd0);
        fcnt_d = fcnt_q + 4'd1;
        if (fcnt_q == FETCH_WORDS) state_d = ST_HDR;
      end
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_word;
        m_axis_tlast  = (beat_q == BEATS_WACK - 4'd1) && !is_rd_q;
        if (m_axis_tready) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == BEATS_WACK - 4'd1) begin
            if (is_rd_q) begin
              state_d = ST_DATA;
            end else begin
              state_d   = ST_IDLE;
              pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
          end
        end
      end
      ST_DATA: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = buf_rd;
        m_axis_tlast  = (beat_q == BEATS_RRSP - 4'd1);
        if (m_axis_tready) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == BEATS_RRSP - 4'd1) begin
            state_d   = ST_IDLE;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      fcnt_q    <= '0;
      pkt_cnt_q <= '0;
      is_rd_q   <= 1'b0;
      key_q     <= '0;
      dst_q     <= '0;
      src_q     <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      fcnt_q    <= fcnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      if (cmd_acc) begin
        is_rd_q <= cmd_type;
        key_q   <= cmd_key;
        dst_q   <= cmd_dst_mac;
        src_q   <= cmd_src_mac;
      end
    end
  end

  assign m_axis_tstrb = '1;
  assign m_axis_tuser = '0;
  assign pkt_cnt      = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ualink_rsp_tx.sv
`default_nettype none
// tb_ualink_rsp_tx: directed scenario tasks for the UALink response transmitter.
// Rev 1.0
module tb_ualink_rsp_tx;

  logic         axi_aclk = 1'b0;
  logic         axi_resetn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_type = 1'b0;
  logic [63:0]  cmd_key = '0;
  logic [47:0]  cmd_dst_mac = '0;
  logic [47:0]  cmd_src_mac = '0;
  logic         mem_rd_en;
  logic [7:0]   mem_rd_addr;
  logic [63:0]  mem_rd_data = '0;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic [31:0]  pkt_cnt;

  ualink_rsp_tx #(
    .C_M_AXIS_DATA_WIDTH  (64),
    .C_M_AXIS_TUSER_WIDTH (128),
    .MEM_ADDR_WIDTH       (8)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_resetn    (axi_resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_type      (cmd_type),
    .cmd_key       (cmd_key),
    .cmd_dst_mac   (cmd_dst_mac),
    .cmd_src_mac   (cmd_src_mac),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  int pass_cnt = 0;
  int check_cnt = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  logic [63:0] mon_data[$];
  bit          mon_last[$];
  int          mon_cyc[$];
  logic [7:0]  addr_log[$];
  int          addr_cyc[$];
  int          stall_err = 0;
  int          stall_seen = 0;
  int          side_err = 0;
  bit          stall_pend = 1'b0;
  logic [63:0] held_data;
  logic        held_last;

  localparam logic [47:0] DST = 48'h0011_2233_4455;
  localparam logic [47:0] SRC = 48'hAABB_CCDD_EEFF;

  always @(posedge axi_aclk) cyc <= cyc + 1;

  // Synchronous memory: word i reads back as the byte i replicated.
  always @(posedge axi_aclk) if (mem_rd_en) mem_rd_data <= {8{mem_rd_addr}};

  always @(posedge axi_aclk) begin
    #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge axi_aclk) begin
    if (axi_resetn && mem_rd_en) begin
      addr_log.push_back(mem_rd_addr);
      addr_cyc.push_back(cyc);
    end
    if (!axi_resetn) begin
      stall_pend = 1'b0;
    end else if (m_axis_tvalid) begin
      if (m_axis_tstrb !== 8'hFF || m_axis_tuser !== '0) side_err++;
      if (stall_pend && (m_axis_tdata !== held_data || m_axis_tlast !== held_last)) stall_err++;
      if (m_axis_tready) begin
        mon_data.push_back(m_axis_tdata);
        mon_last.push_back(m_axis_tlast);
        mon_cyc.push_back(cyc);
        stall_pend = 1'b0;
      end else begin
        stall_pend = 1'b1;
        held_data  = m_axis_tdata;
        held_last  = m_axis_tlast;
        stall_seen++;
      end
    end else if (stall_pend) begin
      stall_err++;
      stall_pend = 1'b0;
    end
  end

  function automatic logic [63:0] exp_beat(input logic rd, input logic [63:0] key,
                                           input logic [47:0] dst, input logic [47:0] src,
                                           input int i);
    logic [7:0] b;
    case (i)
      0: return {src[15:0], dst};
      1: return {(rd ? 8'h81 : 8'h82), 8'h45, 16'h0008, src[47:16]};
      2: return rd ? 64'hC0A8_0001_0011_4000 : 64'h2A00_0001_0011_4000;
      3: return rd ? 64'hB0B0_0000_C0A8_0002 : 64'hB0B0_0000_2A00_0002;
      4: return rd ? 64'h0070_0000_1389_1389 : 64'h0030_0000_1389_1389;
      5: return key;
      default: begin
        b = key[7:0] + 8'(i - 6);
        return {8{b}};
      end
    endcase
  endfunction

  task automatic clear_logs();
    mon_data.delete(); mon_last.delete(); mon_cyc.delete();
    addr_log.delete(); addr_cyc.delete();
  endtask

  task automatic send_cmd(input logic rd, input logic [63:0] key, input logic [47:0] dst,
                          input logic [47:0] src, output int acc_cyc);
    @(negedge axi_aclk);
    cmd_valid = 1'b1; cmd_type = rd; cmd_key = key; cmd_dst_mac = dst; cmd_src_mac = src;
    acc_cyc = -1;
    for (int k = 0; k < 500; k++) begin
      if (cmd_ready) begin
        acc_cyc = cyc + 1;
        @(posedge axi_aclk);
        #1 cmd_valid = 1'b0;
        return;
      end
      @(negedge axi_aclk);
    end
    cmd_valid = 1'b0;
    check_cnt++;
    $display("FAIL cmd_accept timeout: cmd_ready never high, expected 1");
  endtask

  task automatic wait_beats(input int n, input string nm);
    int k = 0;
    while (mon_data.size() < n && k < 3000) begin
      @(posedge axi_aclk);
      k++;
    end
    repeat (3) @(posedge axi_aclk);
    #1;
    check_cnt++;
    if (mon_data.size() != n)
      $display("FAIL %s beat_count: got %0d expected %0d", nm, mon_data.size(), n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    axi_resetn = 1'b0;
    repeat (3) @(posedge axi_aclk);
    #2;
    check_cnt++;
    if ({cmd_ready, m_axis_tvalid, m_axis_tlast, mem_rd_en} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {cmd_ready, m_axis_tvalid, m_axis_tlast, mem_rd_en});
    else pass_cnt++;
    check_cnt++;
    if (m_axis_tdata !== 64'd0 || mem_rd_addr !== 8'd0 || pkt_cnt !== 32'd0)
      $display("FAIL reset_data: tdata %h addr %h pkt_cnt %0d expected all zero", m_axis_tdata, mem_rd_addr, pkt_cnt);
    else pass_cnt++;
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
    @(posedge axi_aclk);
    #1;
    check_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release cmd_ready: got %b expected 1", cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_write_ack();
    int acc;
    logic [63:0] key = 64'h5A30303030309896;
    clear_logs();
    send_cmd(1'b0, key, DST, SRC, acc);
    wait_beats(6, "wack");
    for (int i = 0; i < 6 && i < mon_data.size(); i++) begin
      check_cnt++;
      if (mon_data[i] !== exp_beat(1'b0, key, DST, SRC, i) || mon_last[i] !== (i == 5))
        $display("FAIL wack beat%0d: got %h last %b expected %h last %b", i, mon_data[i], mon_last[i],
                 exp_beat(1'b0, key, DST, SRC, i), (i == 5));
      else pass_cnt++;
    end
    check_cnt++;
    if (mon_cyc.size() > 0 && mon_cyc[0] - acc + 1 !== 1)
      $display("FAIL wack latency: got %0d expected 1", mon_cyc[0] - acc + 1);
    else pass_cnt++;
    check_cnt++;
    if (pkt_cnt !== 32'd1) $display("FAIL wack pkt_cnt: got %0d expected 1", pkt_cnt);
    else pass_cnt++;
    check_cnt++;
    if (addr_log.size() != 0) $display("FAIL wack mem_rd: got %0d reads expected 0", addr_log.size());
    else pass_cnt++;
  endtask

  task automatic test_read_resp(input logic [7:0] base, input string nm, input int exp_pkts);
    int acc;
    logic [63:0] key = {56'hDEAD_BEEF_0000_00, base};
    clear_logs();
    send_cmd(1'b1, key, DST, SRC, acc);
    wait_beats(14, nm);
    check_cnt++;
    if (addr_log.size() != 8) $display("FAIL %s rd_count: got %0d expected 8", nm, addr_log.size());
    else pass_cnt++;
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      check_cnt++;
      if (addr_log[i] !== 8'(base + 8'(i)) || addr_cyc[i] !== addr_cyc[0] + i)
        $display("FAIL %s rd_addr%0d: got %h @%0d expected %h @%0d", nm, i, addr_log[i], addr_cyc[i],
                 8'(base + 8'(i)), addr_cyc[0] + i);
      else pass_cnt++;
    end
    for (int i = 0; i < 14 && i < mon_data.size(); i++) begin
      check_cnt++;
      if (mon_data[i] !== exp_beat(1'b1, key, DST, SRC, i) || mon_last[i] !== (i == 13))
        $display("FAIL %s beat%0d: got %h last %b expected %h last %b", nm, i, mon_data[i], mon_last[i],
                 exp_beat(1'b1, key, DST, SRC, i), (i == 13));
      else pass_cnt++;
    end
    check_cnt++;
    if (mon_cyc.size() > 0 && mon_cyc[0] - acc + 1 !== 10)
      $display("FAIL %s latency: got %0d expected 10", nm, mon_cyc[0] - acc + 1);
    else pass_cnt++;
    check_cnt++;
    if (pkt_cnt !== 32'(exp_pkts)) $display("FAIL %s pkt_cnt: got %0d expected %0d", nm, pkt_cnt, exp_pkts);
    else pass_cnt++;
  endtask

  task automatic test_random_tready();
    int acc, n, bad;
    logic rd;
    logic [63:0] key;
    logic [47:0] dst, src;
    bad = 0;
    rand_rdy = 1'b1;
    for (int p = 0; p < 20; p++) begin
      rd  = (p % 3 != 0);
      key = {32'h1234_0000 + 32'(p), 24'h0, 8'(p * 13)};
      dst = DST ^ 48'(p);
      src = SRC + 48'(p * 7);
      n   = rd ? 14 : 6;
      clear_logs();
      send_cmd(rd, key, dst, src, acc);
      wait_beats(n, "rand");
      for (int i = 0; i < n && i < mon_data.size(); i++)
        if (mon_data[i] !== exp_beat(rd, key, dst, src, i) || mon_last[i] !== (i == n - 1)) begin
          bad++;
          $display("FAIL rand pkt%0d beat%0d: got %h expected %h", p, i, mon_data[i], exp_beat(rd, key, dst, src, i));
        end
    end
    rand_rdy = 1'b0;
    repeat (2) @(posedge axi_aclk);
    #1;
    check_cnt++;
    if (bad != 0) $display("FAIL rand beats: got %0d bad beats expected 0", bad);
    else pass_cnt++;
    check_cnt++;
    if (stall_err != 0 || stall_seen == 0)
      $display("FAIL rand stall: got %0d stall errors over %0d stalls expected 0 errors, >0 stalls", stall_err, stall_seen);
    else pass_cnt++;
    check_cnt++;
    if (pkt_cnt !== 32'd23) $display("FAIL rand pkt_cnt: got %0d expected 23", pkt_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_packet();
    int acc, k;
    logic [63:0] key = 64'h0BAD_F00D_0000_0020;
    clear_logs();
    send_cmd(1'b1, key, DST, SRC, acc);
    k = 0;
    while (mon_data.size() < 8 && k < 500) begin
      @(posedge axi_aclk);
      k++;
    end
    check_cnt++;
    if (mon_data.size() != 8) $display("FAIL rstmid reach_beat8: got %0d beats expected 8", mon_data.size());
    else pass_cnt++;
    #2 axi_resetn = 1'b0;
    #1;
    check_cnt++;
    if ({m_axis_tvalid, m_axis_tlast, mem_rd_en, cmd_ready} !== 4'b0000 || m_axis_tdata !== 64'd0 || pkt_cnt !== 32'd0)
      $display("FAIL rstmid outputs: ctrl %b tdata %h pkt_cnt %0d expected zero",
               {m_axis_tvalid, m_axis_tlast, mem_rd_en, cmd_ready}, m_axis_tdata, pkt_cnt);
    else pass_cnt++;
    repeat (2) @(negedge axi_aclk);
    #2 axi_resetn = 1'b1;
    clear_logs();
    repeat (5) @(posedge axi_aclk);
    #1;
    check_cnt++;
    if (mon_data.size() != 0 || m_axis_tvalid !== 1'b0)
      $display("FAIL rstmid partial: got %0d beats tvalid %b expected 0 beats", mon_data.size(), m_axis_tvalid);
    else pass_cnt++;
    key = 64'hCAFE_0000_0000_0042;
    send_cmd(1'b0, key, DST, SRC, acc);
    wait_beats(6, "rstmid_next");
    for (int i = 0; i < 6 && i < mon_data.size(); i++) begin
      check_cnt++;
      if (mon_data[i] !== exp_beat(1'b0, key, DST, SRC, i) || mon_last[i] !== (i == 5))
        $display("FAIL rstmid_next beat%0d: got %h expected %h", i, mon_data[i], exp_beat(1'b0, key, DST, SRC, i));
      else pass_cnt++;
    end
    check_cnt++;
    if (pkt_cnt !== 32'd1) $display("FAIL rstmid pkt_cnt: got %0d expected 1", pkt_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] keys [3];
    int acc, guard;
    keys[0] = 64'h1111_1111_1111_1111;
    keys[1] = 64'h2222_2222_2222_2222;
    keys[2] = 64'h3333_3333_3333_3333;
    clear_logs();
    acc = 0;
    guard = 0;
    @(negedge axi_aclk);
    cmd_valid = 1'b1; cmd_type = 1'b0; cmd_key = keys[0]; cmd_dst_mac = DST; cmd_src_mac = SRC;
    while (acc < 3 && guard < 500) begin
      if (cmd_ready) begin
        @(posedge axi_aclk);
        #1;
        acc++;
        if (acc < 3) cmd_key = keys[acc];
        else cmd_valid = 1'b0;
      end
      @(negedge axi_aclk);
      guard++;
    end
    cmd_valid = 1'b0;
    check_cnt++;
    if (acc != 3) $display("FAIL b2b accepted: got %0d expected 3", acc);
    else pass_cnt++;
    wait_beats(18, "b2b");
    for (int i = 0; i < 18 && i < mon_data.size(); i++) begin
      check_cnt++;
      if (mon_data[i] !== exp_beat(1'b0, keys[i / 6], DST, SRC, i % 6) || mon_last[i] !== (i % 6 == 5))
        $display("FAIL b2b beat%0d: got %h last %b expected %h last %b", i, mon_data[i], mon_last[i],
                 exp_beat(1'b0, keys[i / 6], DST, SRC, i % 6), (i % 6 == 5));
      else pass_cnt++;
    end
    if (mon_cyc.size() == 18) begin
      check_cnt++;
      if (mon_cyc[6] - mon_cyc[5] != 2 || mon_cyc[12] - mon_cyc[11] != 2)
        $display("FAIL b2b gap: got %0d,%0d cycles expected 2,2", mon_cyc[6] - mon_cyc[5], mon_cyc[12] - mon_cyc[11]);
      else pass_cnt++;
    end
    check_cnt++;
    if (pkt_cnt !== 32'd4) $display("FAIL b2b pkt_cnt: got %0d expected 4", pkt_cnt);
    else pass_cnt++;
    check_cnt++;
    if (side_err != 0) $display("FAIL sideband tstrb/tuser: got %0d bad beats expected 0", side_err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_resp(8'h10, "rrsp", 2);
    test_read_resp(8'hFC, "wrap", 3);
    test_random_tready();
    test_reset_mid_packet();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ualink_rsp_tx.md
UALINK_RSP_TX -- requirements
Module: ualink_rsp_tx

Interface
REQ-001 Parameters SHALL be: C_M_AXIS_DATA_WIDTH, default 64, stream data width (only 64 supported); C_M_AXIS_TUSER_WIDTH, default 128, sideband width; MEM_ADDR_WIDTH, default 8, word-address width of the memory read port.
REQ-002 axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-003 axi_resetn  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  response command present.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 cmd_type  in  1  0 = write-ack, 1 = read-response.
REQ-007 cmd_key  in  64  request key word (header word 5); bits [MEM_ADDR_WIDTH-1:0] give the base word address.
REQ-008 cmd_dst_mac  in  48  destination MAC, which is the requester's source MAC.
REQ-009 cmd_src_mac  in  48  source MAC of this node.
REQ-010 mem_rd_en  out  1  memory read strobe.
REQ-011 mem_rd_addr  out  MEM_ADDR_WIDTH  memory word address.
REQ-012 mem_rd_data  in  64  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 m_axis_tdata/tstrb/tuser/tvalid/tready/tlast  out/out/out/out/in/out  64/8/128/1/1/1  AXI4-Stream master.
REQ-014 pkt_cnt  out  32  count of completed response packets.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, HDR and DATA.
REQ-016 IDLE: cmd_ready=1; on accept, latch all cmd_* fields; read-response goes to FETCH, write-ack goes to HDR; cmd_ready=0 in every other state.
REQ-017 FETCH: issue 8 consecutive mem_rd_en cycles at addresses base+0..base+7, wrapping modulo 2^MEM_ADDR_WIDTH; capture each mem_rd_data into an 8x64 buffer on the following cycle; enter HDR the cycle after the 8th capture (FETCH lasts 9 cycles).
REQ-018 HDR: drive beats 0..5 with tvalid=1, advancing only on tvalid&&tready.
REQ-019 Beat 0 SHALL be {cmd_src_mac[15:0], cmd_dst_mac}.
REQ-020 Beat 1 SHALL be {opcode, 8'h45, 16'h0008, cmd_src_mac[47:16]}; opcode is 8'h81 for read-response and 8'h82 for write-ack.
REQ-021 Beats 2..4 SHALL be package template constants chosen per cmd_type; beat 5 SHALL be the latched cmd_key.
REQ-022 Write-ack: tlast=1 on beat 5 (6 beats total), then return to IDLE.
REQ-023 Read-response: after beat 5 enter DATA and emit buffer words 0..7 as beats 6..13; tlast=1 only on beat 13 (14 beats total), then return to IDLE.
REQ-024 tstrb=8'hFF and tuser=0 on every beat; tvalid=0 in IDLE and FETCH.
REQ-025 With tvalid high and tready low, tdata/tlast/tvalid SHALL hold stable; tvalid SHALL never drop mid-packet.
REQ-026 With tready held high, first beat SHALL be presented: write-ack 1 cycle after command accept; read-response 10 cycles after accept.
REQ-027 pkt_cnt SHALL increment on each tlast handshake and wrap 2^32-1 -> 0.
REQ-028 A command arriving while busy SHALL wait (cmd_ready=0) and SHALL NOT be dropped.
REQ-029 Back-to-back commands: the IDLE state after a tlast handshake SHALL accept the next command in the same cycle it is entered (1 bubble beat minimum).

Reset
REQ-030 axi_resetn low SHALL asynchronously force: state IDLE; cmd_ready 0 while reset asserted, 1 from the first cycle after release; tvalid/tlast/mem_rd_en 0; tdata/mem_rd_addr 0; pkt_cnt 0.
REQ-031 Reset mid-packet SHALL abandon the packet; no partial beats after release; the buffer needs no reset.

Structure
REQ-032 Shared package ualink_pkg SHALL hold: opcode constants (request 8'h01/8'h02, response 8'h81/8'h82), header template words 2..4 per type, beat counts (6 and 14), and the state encoding.
REQ-033 One sub-module, ualink_rsp_buf (8x64 register buffer with write index/read index), SHALL be used; all else is inline.

Verification
REQ-034 Write-ack, cmd_key=64'h5A30303030309896, tready=1 -> 6 beats; beat1[63:56]=8'h82; beat5=cmd_key; tlast on beat 5; pkt_cnt=1.
REQ-035 Read-response, base 8'h10, memory word i = {8{i[7:0]}} -> mem_rd_addr 8'h10..8'h17 in 8 cycles; beats 6..13 = 64'h1010..10 through 64'h1717..17; tlast on beat 13.
REQ-036 Read-response with base 8'hFC -> addresses FC,FD,FE,FF,00,01,02,03 (wrap).
REQ-037 Random tready (50%) over 20 mixed packets -> beat sequence identical to the tready=1 case; no data change while stalled; pkt_cnt=20.
REQ-038 axi_resetn pulsed low at beat 8 of a read-response -> outputs zero immediately; the next command produces a complete, correct packet.
REQ-039 cmd_valid held high for 3 queued commands -> exactly 3 packets, 1 idle cycle between each tlast and the next first beat.
